// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller: credit accumulation, per-slot price/stock
// checks, dispense with change, refund, idle timeout, restock and coded alarms.
module vending_ctrl_multi #(
    parameter int N_PROD      = 4,
    parameter int VAL_W       = 8,
    parameter int STOCK_W     = 4,
    parameter int SALES_W     = 16,
    parameter int TIMEOUT_CYC = 1000,
    localparam int IDX_W      = $clog2(N_PROD),
    localparam int TMR_W      = $clog2(TIMEOUT_CYC)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_coin_valid,
    input  logic [VAL_W-1:0]        i_coin_value,
    input  logic                    i_sel_valid,
    input  logic [IDX_W-1:0]        i_sel_idx,
    input  logic                    i_cancel,
    input  logic                    i_alarm_ack,
    input  logic [N_PROD*VAL_W-1:0] i_prices,
    input  logic                    i_restock_valid,
    input  logic [IDX_W-1:0]        i_restock_idx,
    input  logic [STOCK_W-1:0]      i_restock_qty,
    output logic [2:0]              o_state,
    output logic [VAL_W-1:0]        o_credit,
    output logic                    o_coin_reject,
    output logic                    o_dispense_valid,
    output logic [IDX_W-1:0]        o_dispense_idx,
    output logic                    o_change_valid,
    output logic [VAL_W-1:0]        o_change_amt,
    output logic                    o_alarm,
    output logic [1:0]              o_alarm_code,
    output logic [N_PROD-1:0]       o_sold_out,
    output logic [SALES_W-1:0]      o_total_sales
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CREDIT = 3'd1,
        S_VEND   = 3'd2,
        S_REFUND = 3'd3,
        S_ALARM  = 3'd4
    } state_t;

    state_t             r_state;
    logic [VAL_W-1:0]   r_credit;
    logic [TMR_W-1:0]   r_timer;
    logic [STOCK_W-1:0] r_stock [N_PROD];

    logic [STOCK_W-1:0] w_stock_nxt [N_PROD];
    logic [VAL_W-1:0]   w_price;
    logic [STOCK_W-1:0] w_stock_sel;
    logic [VAL_W:0]     w_sum;
    logic               w_idx_ok;
    logic               w_sel;
    logic               w_vend_go;
    logic               w_coin_ok;
    logic               w_rst_idx_ok;

    assign o_state  = r_state;
    assign o_credit = r_credit;

    assign w_idx_ok     = {1'b0, i_sel_idx} < (IDX_W+1)'(N_PROD);
    assign w_rst_idx_ok = {1'b0, i_restock_idx} < (IDX_W+1)'(N_PROD);
    assign w_sum        = {1'b0, r_credit} + {1'b0, i_coin_value};
    assign w_sel        = (r_state == S_CREDIT) && i_sel_valid && !i_cancel;
    assign w_vend_go    = w_sel && w_idx_ok && (w_stock_sel != '0)
                          && (r_credit >= w_price);

    // Price and stock of the selected slot; zero when the index is out of range
    always_comb begin
        w_price     = '0;
        w_stock_sel = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (i_sel_idx == IDX_W'(i)) begin
                w_price     = i_prices[i*VAL_W +: VAL_W];
                w_stock_sel = r_stock[i];
            end
        end
    end

    // Coin acceptance: IDLE takes any coin, CREDIT only an unopposed, non-overflowing one
    always_comb begin
        w_coin_ok = 1'b0;
        if (r_state == S_IDLE)
            w_coin_ok = i_coin_valid;
        else if (r_state == S_CREDIT)
            w_coin_ok = i_coin_valid && !i_cancel && !i_sel_valid && !w_sum[VAL_W];
    end

    // Next stock per slot: vend decrement plus saturating restock
    always_comb begin
        for (int i = 0; i < N_PROD; i++) begin
            logic [STOCK_W:0] v_tmp;
            v_tmp = {1'b0, r_stock[i]};
            if (i_restock_valid && w_rst_idx_ok && i_restock_idx == IDX_W'(i))
                v_tmp = v_tmp + {1'b0, i_restock_qty};
            if (w_vend_go && i_sel_idx == IDX_W'(i))
                v_tmp = v_tmp - 1'b1;
            w_stock_nxt[i] = v_tmp[STOCK_W] ? '1 : v_tmp[STOCK_W-1:0];
        end
    end

    // Stock registers and the sold-out flags that trail them by one cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_PROD; i++) r_stock[i] <= '0;
            o_sold_out <= '1;
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                r_stock[i]    <= w_stock_nxt[i];
                o_sold_out[i] <= (r_stock[i] == '0);
            end
        end
    end

    // Main controller FSM with registered pulse, alarm and sales outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_credit         <= '0;
            r_timer          <= '0;
            o_coin_reject    <= 1'b0;
            o_dispense_valid <= 1'b0;
            o_dispense_idx   <= '0;
            o_change_valid   <= 1'b0;
            o_change_amt     <= '0;
            o_alarm          <= 1'b0;
            o_alarm_code     <= 2'd0;
            o_total_sales    <= '0;
        end else begin
            o_coin_reject    <= i_coin_valid && !w_coin_ok;
            o_dispense_valid <= 1'b0;
            o_change_valid   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_coin_valid) begin
                        r_credit <= i_coin_value;
                        r_timer  <= '0;
                        r_state  <= S_CREDIT;
                    end
                end
                S_CREDIT: begin
                    if (i_cancel || (!i_sel_valid && !w_coin_ok
                                     && r_timer == TMR_W'(TIMEOUT_CYC-1))) begin
                        o_change_valid <= (r_credit != '0);
                        o_change_amt   <= r_credit;
                        r_credit       <= '0;
                        r_state        <= S_REFUND;
                    end else if (i_sel_valid) begin
                        r_timer <= '0;
                        if (!w_idx_ok) begin
                            o_alarm      <= 1'b1;
                            o_alarm_code <= 2'd3;
                            r_state      <= S_ALARM;
                        end else if (w_stock_sel == '0) begin
                            o_alarm      <= 1'b1;
                            o_alarm_code <= 2'd2;
                            r_state      <= S_ALARM;
                        end else if (r_credit < w_price) begin
                            o_alarm      <= 1'b1;
                            o_alarm_code <= 2'd1;
                            r_state      <= S_ALARM;
                        end else begin
                            o_dispense_valid <= 1'b1;
                            o_dispense_idx   <= i_sel_idx;
                            o_change_valid   <= 1'b1;
                            o_change_amt     <= r_credit - w_price;
                            o_total_sales    <= o_total_sales + SALES_W'(w_price);
                            r_credit         <= '0;
                            r_state          <= S_VEND;
                        end
                    end else if (w_coin_ok) begin
                        r_credit <= w_sum[VAL_W-1:0];
                        r_timer  <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_VEND, S_REFUND: begin
                    r_state <= S_IDLE;
                end
                S_ALARM: begin
                    if (i_cancel) begin
                        o_alarm        <= 1'b0;
                        o_alarm_code   <= 2'd0;
                        o_change_valid <= (r_credit != '0);
                        o_change_amt   <= r_credit;
                        r_credit       <= '0;
                        r_state        <= S_REFUND;
                    end else if (i_alarm_ack) begin
                        o_alarm      <= 1'b0;
                        o_alarm_code <= 2'd0;
                        r_state      <= S_CREDIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Directed bench for vending_ctrl_multi: vends, alarms, refunds, timeout,
// overflow, restock saturation and asynchronous reset.
module tb_vending_ctrl_multi;

    localparam int N_PROD  = 3;
    localparam int VAL_W   = 8;
    localparam int STOCK_W = 4;
    localparam int SALES_W = 16;
    localparam int TMO     = 20;
    localparam int IDX_W   = $clog2(N_PROD);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    coin_valid;
    logic [VAL_W-1:0]        coin_value;
    logic                    sel_valid;
    logic [IDX_W-1:0]        sel_idx;
    logic                    cancel;
    logic                    alarm_ack;
    logic [N_PROD*VAL_W-1:0] prices;
    logic                    restock_valid;
    logic [IDX_W-1:0]        restock_idx;
    logic [STOCK_W-1:0]      restock_qty;
    logic [2:0]              state;
    logic [VAL_W-1:0]        credit;
    logic                    coin_reject;
    logic                    dispense_valid;
    logic [IDX_W-1:0]        dispense_idx;
    logic                    change_valid;
    logic [VAL_W-1:0]        change_amt;
    logic                    alarm;
    logic [1:0]              alarm_code;
    logic [N_PROD-1:0]       sold_out;
    logic [SALES_W-1:0]      total_sales;

    int total = 0;
    int bad   = 0;

    vending_ctrl_multi #(
        .N_PROD(N_PROD), .VAL_W(VAL_W), .STOCK_W(STOCK_W),
        .SALES_W(SALES_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_coin_valid(coin_valid), .i_coin_value(coin_value),
        .i_sel_valid(sel_valid), .i_sel_idx(sel_idx),
        .i_cancel(cancel), .i_alarm_ack(alarm_ack),
        .i_prices(prices),
        .i_restock_valid(restock_valid), .i_restock_idx(restock_idx),
        .i_restock_qty(restock_qty),
        .o_state(state), .o_credit(credit), .o_coin_reject(coin_reject),
        .o_dispense_valid(dispense_valid), .o_dispense_idx(dispense_idx),
        .o_change_valid(change_valid), .o_change_amt(change_amt),
        .o_alarm(alarm), .o_alarm_code(alarm_code),
        .o_sold_out(sold_out), .o_total_sales(total_sales)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [VAL_W-1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [IDX_W-1:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic ack();
        alarm_ack = 1'b1;
        tick();
        alarm_ack = 1'b0;
    endtask

    task automatic restock(input logic [IDX_W-1:0] idx, input logic [STOCK_W-1:0] q);
        restock_valid = 1'b1;
        restock_idx   = idx;
        restock_qty   = q;
        tick();
        restock_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        coin_valid = 0; coin_value = 0; sel_valid = 0; sel_idx = 0;
        cancel = 0; alarm_ack = 0; restock_valid = 0; restock_idx = 0;
        restock_qty = 0;
        prices = {8'd0, 8'd50, 8'd30};
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_credit", credit, 0);
        check("rst_soldout", sold_out, 3'b111);
        check("rst_sales", total_sales, 0);
        check("rst_alarm", alarm, 0);
        check("rst_chg", change_amt, 0);
        rst = 1'b0;
        tick();

        restock(1, 3);
        tick();
        check("soldout_r1", sold_out, 3'b101);
        coin(20); coin(20); coin(20);
        check("credit60", credit, 60);
        check("state_credit", state, 1);
        sel(1);
        check("vend_state", state, 2);
        check("vend_disp", dispense_valid, 1);
        check("vend_idx", dispense_idx, 1);
        check("vend_chgv", change_valid, 1);
        check("vend_chg", change_amt, 10);
        check("vend_sales", total_sales, 50);
        check("vend_credit", credit, 0);
        tick();
        check("vend_idle", state, 0);
        check("vend_pulse_off", dispense_valid, 0);

        coin(20);
        sel(1);
        check("al1_state", state, 4);
        check("al1_alarm", alarm, 1);
        check("al1_code", alarm_code, 1);
        check("al1_credit", credit, 20);
        coin(5);
        check("al1_coinrej", coin_reject, 1);
        check("al1_credit2", credit, 20);
        ack();
        check("ack_state", state, 1);
        check("ack_alarm", alarm, 0);
        check("ack_code", alarm_code, 0);
        coin(40);
        sel(1);
        check("al1_vchg", change_amt, 10);
        check("al1_vdisp", dispense_valid, 1);
        check("al1_sales", total_sales, 100);
        tick();

        coin(30);
        cancel = 1'b1;
        coin(10);
        cancel = 1'b0;
        check("cxl_rej", coin_reject, 1);
        check("cxl_state", state, 3);
        check("cxl_chgv", change_valid, 1);
        check("cxl_chg", change_amt, 30);
        check("cxl_credit", credit, 0);
        tick();
        check("cxl_idle", state, 0);

        coin(10);
        n = 0;
        while (n < 100 && change_valid !== 1'b1) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_chg", change_amt, 10);
        check("tmo_state", state, 3);
        tick();
        check("tmo_idle", state, 0);

        coin(100);
        sel(0);
        check("code2", alarm_code, 2);
        ack();
        sel(3);
        check("code3", alarm_code, 3);
        check("code3_state", state, 4);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("alcxl_chg", change_amt, 100);
        check("alcxl_alarm", alarm, 0);
        tick();
        coin(250);
        coin(10);
        check("ovf_rej", coin_reject, 1);
        check("ovf_credit", credit, 250);
        coin(5);
        check("max_rej", coin_reject, 0);
        check("max_credit", credit, 255);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("max_chg", change_amt, 255);
        tick();

        restock(2, 15);
        tick();
        check("soldout_s2", sold_out[2], 0);
        coin(0);
        restock_valid = 1'b1;
        restock_idx   = 2;
        restock_qty   = 5;
        sel(2);
        restock_valid = 1'b0;
        check("sat_chgv", change_valid, 1);
        check("sat_chg", change_amt, 0);
        tick();
        for (int k = 0; k < 14; k++) begin
            coin(0);
            sel(2);
            tick();
        end
        check("sat_left1", sold_out[2], 0);
        coin(0);
        sel(2);
        tick();
        check("sat_empty", sold_out[2], 1);
        check("sat_sales", total_sales, 100);

        coin(40);
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_credit", credit, 0);
        check("arst_soldout", sold_out, 3'b111);
        check("arst_sales", total_sales, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
